amp_mul_scheduler: RTL and testbench

Time-multiplexes one pipelined signed 32x32 multiplier core (Mul32-style: clk, ce, sclr, a, b, p) across NUM_VOICES voices. On each Sample_tick it issues one amplitude x oscillator product per cycle, tracks each voice through the multiplier latency with a tag pipeline, and accumulates the products. It then emits one saturated 32-bit mixed sample. It sits between the per-voice oscillator/envelope registers and the output mixer/DAC path.

---
 rtl/amp_mul_scheduler_pkg.sv | 34 +++
 rtl/amp_mul_scheduler_tag_pipe.sv | 28 ++
 rtl/amp_mul_scheduler.sv | 163 ++++++++++++++++
 tb/tb_amp_mul_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/amp_mul_scheduler_pkg.sv
// Shared widths, FSM state type and output saturation for the voice mixer.
package amp_pkg;

  localparam int MUL_W  = 32;
  localparam int PROD_W = 64;
  localparam int MIX_W  = 32;

  // Wide enough to hold any shifted accumulator (64 + clog2(16) bits) plus sign headroom.
  localparam int SAT_W = 80;

  localparam logic signed [SAT_W-1:0] SAT_MAX = SAT_W'(64'sh0000_0000_7FFF_FFFF);
  localparam logic signed [SAT_W-1:0] SAT_MIN = SAT_W'(64'shFFFF_FFFF_8000_0000);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } amp_state_e;

  // Clamp a sign-extended value into the signed 32-bit range.
  function automatic logic [MIX_W-1:0] saturate32(input logic signed [SAT_W-1:0] v);
    logic [MIX_W-1:0] r;
    if (v > SAT_MAX) begin
      r = 32'h7FFF_FFFF;
    end else if (v < SAT_MIN) begin
      r = 32'h8000_0000;
    end else begin
      r = v[MIX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/amp_mul_scheduler_tag_pipe.sv
// Voice-valid tag delay line; advances in lock-step with the multiplier's ce.
module amp_tag_pipe #(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic clr_n_i,
  input  logic ce_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] pipe_q;

  // Shift one tag per enabled cycle; a clear drops every in-flight tag.
  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      pipe_q <= '0;
    end else if (ce_i) begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/amp_mul_scheduler.sv
// Shares one pipelined 32x32 multiplier across all voices and mixes the
// enabled amp x osc products into one saturated sample per Sample_tick.
//
// state | meaning
// IDLE  | waiting for Sample_tick, multiplier idle
// ISSUE | one voice's operands presented per cycle
// DRAIN | zero operands pushed until the last product leaves the multiplier
// DONE  | Mix_out updated, Mix_valid pulses
module amp_mul_scheduler
  import amp_pkg::*;
#(
  parameter int NUM_VOICES  = 4,
  parameter int MUL_LATENCY = 4,
  parameter int OUT_SHIFT   = 31
) (
  input  logic                         Sys_clk,
  input  logic                         Sys_rst_n,
  input  logic                         Sample_tick,
  input  logic [NUM_VOICES-1:0]        Voice_en,
  input  logic [MUL_W*NUM_VOICES-1:0]  Voice_amp,
  input  logic [MUL_W*NUM_VOICES-1:0]  Voice_osc,
  input  logic                         Overrun_clr,
  output logic                         Mul_ce,
  output logic                         Mul_sclr,
  output logic [MUL_W-1:0]             Mul_a,
  output logic [MUL_W-1:0]             Mul_b,
  input  logic [PROD_W-1:0]            Mul_p,
  output logic [MIX_W-1:0]             Mix_out,
  output logic                         Mix_valid,
  output logic                         Busy,
  output logic                         Overrun
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACC_W = PROD_W + $clog2(NUM_VOICES);
  localparam int DRN_W = 4;

  amp_state_e              state_q;
  logic [IDX_W-1:0]        k_q;
  logic [IDX_W-1:0]        k_nxt;
  logic [DRN_W-1:0]        drn_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_sh;
  logic signed [SAT_W-1:0] sat_in;
  logic                    ce_q;
  logic                    en_q;
  logic                    valid_q;
  logic                    overrun_q;
  logic                    sclr_q;
  logic [MUL_W-1:0]        a_q;
  logic [MUL_W-1:0]        b_q;
  logic [MIX_W-1:0]        mix_q;
  logic                    tag_out;
  logic [MUL_W-1:0]        amp_arr [NUM_VOICES];
  logic [MUL_W-1:0]        osc_arr [NUM_VOICES];

  // Unpack the flattened voice buses and form the running sum including this cycle's product.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      amp_arr[i] = Voice_amp[MUL_W*i +: MUL_W];
      osc_arr[i] = Voice_osc[MUL_W*i +: MUL_W];
    end
    k_nxt   = k_q + IDX_W'(1);
    acc_sum = acc_q + (tag_out ? $signed({{(ACC_W-PROD_W){Mul_p[PROD_W-1]}}, Mul_p})
                               : $signed(ACC_W'(0)));
    acc_sh  = acc_sum >>> OUT_SHIFT;
    sat_in  = $signed({{(SAT_W-ACC_W){acc_sh[ACC_W-1]}}, acc_sh});
  end

  // The clear lags reset by one cycle so the external core is scrubbed after any reset.
  always_ff @(posedge Sys_clk) begin
    sclr_q <= ~Sys_rst_n;
  end

  // Sequencer: issue voices, drain the multiplier, publish the mix.
  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      drn_q     <= '0;
      acc_q     <= '0;
      ce_q      <= 1'b0;
      en_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      mix_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (Sample_tick && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end else if (Overrun_clr) begin
        overrun_q <= 1'b0;
      end
      if ((state_q == ISSUE) || (state_q == DRAIN)) begin
        acc_q <= acc_sum;
      end
      case (state_q)
        IDLE: begin
          if (Sample_tick) begin
            state_q <= ISSUE;
            acc_q   <= '0;
            k_q     <= '0;
            ce_q    <= 1'b1;
            a_q     <= amp_arr[0];
            b_q     <= osc_arr[0];
            en_q    <= Voice_en[0];
          end
        end
        ISSUE: begin
          if (k_q == IDX_W'(NUM_VOICES-1)) begin
            state_q <= DRAIN;
            a_q     <= '0;
            b_q     <= '0;
            en_q    <= 1'b0;
            drn_q   <= DRN_W'(MUL_LATENCY-1);
          end else begin
            k_q  <= k_nxt;
            a_q  <= amp_arr[k_nxt];
            b_q  <= osc_arr[k_nxt];
            en_q <= Voice_en[k_nxt];
          end
        end
        DRAIN: begin
          if (drn_q == '0) begin
            state_q <= DONE;
            ce_q    <= 1'b0;
            mix_q   <= saturate32(sat_in);
            valid_q <= 1'b1;
          end else begin
            drn_q <= drn_q - DRN_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  amp_tag_pipe #(
    .DEPTH(MUL_LATENCY)
  ) u_tag_pipe (
    .clk_i   (Sys_clk),
    .clr_n_i (Sys_rst_n),
    .ce_i    (ce_q),
    .d_i     (en_q),
    .q_o     (tag_out)
  );

  assign Mul_ce    = ce_q;
  assign Mul_sclr  = sclr_q;
  assign Mul_a     = a_q;
  assign Mul_b     = b_q;
  assign Mix_out   = mix_q;
  assign Mix_valid = valid_q;
  assign Busy      = (state_q != IDLE);
  assign Overrun   = overrun_q;

endmodule

// File: tb/tb_amp_mul_scheduler.sv
// Directed and randomized checks of the voice mixer against an arithmetic reference.
module tb_amp_mul_scheduler;

  localparam int N = 4;
  localparam int L = 4;

  logic           Sys_clk = 1'b0;
  logic           Sys_rst_n;
  logic           Sample_tick;
  logic [N-1:0]   Voice_en;
  logic [32*N-1:0] Voice_amp;
  logic [32*N-1:0] Voice_osc;
  logic           Overrun_clr;
  logic           Mul_ce;
  logic           Mul_sclr;
  logic [31:0]    Mul_a;
  logic [31:0]    Mul_b;
  logic [63:0]    Mul_p;
  logic [31:0]    Mix_out;
  logic           Mix_valid;
  logic           Busy;
  logic           Overrun;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] en_v;
  logic [31:0]  amp_v [N];
  logic [31:0]  osc_v [N];

  amp_mul_scheduler #(
    .NUM_VOICES  (N),
    .MUL_LATENCY (L),
    .OUT_SHIFT   (31)
  ) dut (
    .Sys_clk     (Sys_clk),
    .Sys_rst_n   (Sys_rst_n),
    .Sample_tick (Sample_tick),
    .Voice_en    (Voice_en),
    .Voice_amp   (Voice_amp),
    .Voice_osc   (Voice_osc),
    .Overrun_clr (Overrun_clr),
    .Mul_ce      (Mul_ce),
    .Mul_sclr    (Mul_sclr),
    .Mul_a       (Mul_a),
    .Mul_b       (Mul_b),
    .Mul_p       (Mul_p),
    .Mix_out     (Mix_out),
    .Mix_valid   (Mix_valid),
    .Busy        (Busy),
    .Overrun     (Overrun)
  );

  always #5 Sys_clk = ~Sys_clk;

  // Behavioural 4-stage signed multiplier core with ce and sclr.
  logic signed [63:0] mst0, mst1, mst2, mst3;
  always @(posedge Sys_clk) begin
    if (Mul_sclr) begin
      mst0 <= '0; mst1 <= '0; mst2 <= '0; mst3 <= '0;
    end else if (Mul_ce) begin
      mst0 <= 64'($signed(Mul_a)) * 64'($signed(Mul_b));
      mst1 <= mst0;
      mst2 <= mst1;
      mst3 <= mst2;
    end
  end
  assign Mul_p = mst3;

  task automatic step();
    @(posedge Sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sum of enabled amp*osc, scaled by 2^-31 and clamped to signed 32 bits.
  function automatic logic [31:0] ref_mix();
    logic signed [79:0] sum;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      if (en_v[i]) sum = sum + 80'($signed(amp_v[i])) * 80'($signed(osc_v[i]));
    end
    sum = sum >>> 31;
    if (sum > 80'sd2147483647)  return 32'h7FFF_FFFF;
    if (sum < -80'sd2147483648) return 32'h8000_0000;
    return sum[31:0];
  endfunction

  task automatic drive();
    Voice_en = en_v;
    for (int i = 0; i < N; i++) begin
      Voice_amp[32*i +: 32] = amp_v[i];
      Voice_osc[32*i +: 32] = osc_v[i];
    end
  endtask

  task automatic set_all(input logic [N-1:0] en, input logic [31:0] a, input logic [31:0] o);
    en_v = en;
    for (int i = 0; i < N; i++) begin
      amp_v[i] = a;
      osc_v[i] = o;
    end
  endtask

  task automatic run_frame(input string tag);
    logic [31:0] exp;
    int lat;
    drive();
    exp = ref_mix();
    lat = 0;
    Sample_tick = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 1) Sample_tick = 1'b0;
      if (Mix_valid) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'(1 + N + L));
    chk({tag, "_mix"}, 64'(Mix_out), 64'(exp));
    step();
    chk({tag, "_pulse"}, 64'(Mix_valid), 64'd0);
    chk({tag, "_hold"}, 64'(Mix_out), 64'(exp));
  endtask

  initial begin
    int vcnt;
    Sys_rst_n   = 1'b0;
    Sample_tick = 1'b0;
    Overrun_clr = 1'b0;
    Voice_en    = '0;
    Voice_amp   = '0;
    Voice_osc   = '0;

    // Reset held for three cycles.
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_mix",   64'(Mix_out),   64'd0);
      chk("rst_valid", 64'(Mix_valid), 64'd0);
      chk("rst_busy",  64'(Busy),      64'd0);
      chk("rst_ovr",   64'(Overrun),   64'd0);
      chk("rst_ce",    64'(Mul_ce),    64'd0);
      chk("rst_a",     64'(Mul_a),     64'd0);
      chk("rst_b",     64'(Mul_b),     64'd0);
      chk("rst_sclr",  64'(Mul_sclr),  64'd1);
    end
    Sys_rst_n = 1'b1;
    step();
    chk("rel_busy", 64'(Busy), 64'd0);
    chk("rel_sclr", 64'(Mul_sclr), 64'd0);
    for (int c = 0; c < 5; c++) step();

    // Single voice with cycle-exact timing; other voices carry junk but are disabled.
    set_all(4'b0001, 32'h1234_5678, 32'h7654_3210);
    amp_v[0] = 32'h4000_0000;
    osc_v[0] = 32'h4000_0000;
    drive();
    Sample_tick = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 1) Sample_tick = 1'b0;
      chk($sformatf("single_busy_%0d", i),  64'(Busy),      64'(i <= 1 + N + L));
      chk($sformatf("single_ce_%0d", i),    64'(Mul_ce),    64'(i <= N + L));
      chk($sformatf("single_valid_%0d", i), 64'(Mix_valid), 64'(i == 1 + N + L));
      if (i >= 1 + N + L) chk($sformatf("single_mix_%0d", i), 64'(Mix_out), 64'h2000_0000);
    end

    // Saturation both ways.
    set_all(4'b1111, 32'h4000_0000, 32'h4000_0000);
    run_frame("sat_pos");
    chk("sat_pos_val", 64'(Mix_out), 64'h7FFF_FFFF);
    set_all(4'b1111, 32'h8000_0000, 32'h7FFF_FFFF);
    run_frame("sat_neg");
    chk("sat_neg_val", 64'(Mix_out), 64'h8000_0000);

    // Mixed enables with opposite signs cancelling.
    en_v = 4'b1010;
    amp_v[0] = 32'h1111_1111; osc_v[0] = 32'h2222_2222;
    amp_v[1] = 32'h4000_0000; osc_v[1] = 32'h4000_0000;
    amp_v[2] = 32'h3333_3333; osc_v[2] = 32'h0444_4444;
    amp_v[3] = 32'hC000_0000; osc_v[3] = 32'h4000_0000;
    run_frame("mixed");
    chk("mixed_val", 64'(Mix_out), 64'h0);

    // Randomized frames; odd frames use reduced amplitudes to stay out of saturation.
    for (int f = 0; f < 8; f++) begin
      en_v = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        amp_v[i] = $urandom;
        osc_v[i] = $urandom;
        if (f % 2 == 1) amp_v[i] = {{4{amp_v[i][27]}}, amp_v[i][27:0]};
      end
      run_frame($sformatf("rand%0d", f));
    end

    // Overrun: tick 5 cycles in, then a tick plus clear in the DONE cycle.
    set_all(4'b0011, 32'h0100_0000, 32'h0200_0000);
    drive();
    Sample_tick = 1'b1;
    vcnt = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (Mix_valid) vcnt++;
      if (i == 5)  chk("ovr_before", 64'(Overrun), 64'd0);
      if (i == 6)  chk("ovr_set", 64'(Overrun), 64'd1);
      if (i == 9)  chk("ovr_done_valid", 64'(Mix_valid), 64'd1);
      if (i == 10) chk("ovr_set_wins", 64'(Overrun), 64'd1);
      if (i == 10) chk("ovr_idle", 64'(Busy), 64'd0);
      Sample_tick = (i == 5 || i == 9);
      Overrun_clr = (i == 9);
    end
    chk("ovr_one_valid", 64'(vcnt), 64'd1);
    Overrun_clr = 1'b1;
    step();
    Overrun_clr = 1'b0;
    chk("ovr_clr", 64'(Overrun), 64'd0);
    set_all(4'b0111, 32'h2000_0000, 32'h0800_0000);
    run_frame("post_ovr");
    chk("post_ovr_nonzero", 64'(Mix_out != 32'h0), 64'd1);

    // Reset during the second ISSUE cycle aborts the frame.
    set_all(4'b1111, 32'h4000_0000, 32'h1000_0000);
    drive();
    Sample_tick = 1'b1;
    step();
    Sample_tick = 1'b0;
    step();
    Sys_rst_n = 1'b0;
    step();
    step();
    Sys_rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (Mix_valid) vcnt++;
    end
    chk("abort_no_valid", 64'(vcnt), 64'd0);
    chk("abort_mix", 64'(Mix_out), 64'd0);
    chk("abort_busy", 64'(Busy), 64'd0);
    set_all(4'b0101, 32'h0300_0000, 32'hF900_0000);
    run_frame("after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
